// File: rtl/cordic_add_subt_unit.sv
// Multi-cycle signed adder/subtractor serving the CORDIC controller's add/subtract
// handshake: two carry-linked half-width additions, then saturation, then hold until acked.
module cordic_add_subt_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         op_add_subt,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         ready_add_subt,
  output logic         busy,
  output logic [W-1:0] result,
  output logic         overflow
);

  localparam int H = W / 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADD_LO = 3'd1,
    ADD_HI = 3'd2,
    SAT    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t       state_r;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         cin_r;
  logic [H-1:0] sum_lo_r;
  logic [H-1:0] sum_hi_r;
  logic         c_r;
  logic         ovf_r;
  logic [W-1:0] result_r;
  logic         overflow_r;
  logic         ready_r;
  logic         busy_r;

  logic [H:0]   lo_sum_s;
  logic [H-1:0] hi_sum_s;
  logic         ovf_s;
  logic [W-1:0] sat_result_s;

  // Half-width adders, signed-overflow detect and saturation value selection
  always_comb begin
    lo_sum_s     = {1'b0, a_r[H-1:0]} + {1'b0, b_r[H-1:0]} + {{H{1'b0}}, cin_r};
    hi_sum_s     = a_r[W-1:H] + b_r[W-1:H] + {{(H-1){1'b0}}, c_r};
    ovf_s        = (a_r[W-1] == b_r[W-1]) && (hi_sum_s[H-1] != a_r[W-1]);
    sat_result_s = {sum_hi_r, sum_lo_r};
    if (ovf_r) begin
      if (a_r[W-1]) begin
        sat_result_s = {1'b1, {(W-1){1'b0}}};
      end else begin
        sat_result_s = {1'b0, {(W-1){1'b1}}};
      end
    end else begin
      sat_result_s = {sum_hi_r, sum_lo_r};
    end
  end

  // Handshake FSM with operand capture, staged sums and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      a_r        <= {W{1'b0}};
      b_r        <= {W{1'b0}};
      cin_r      <= 1'b0;
      sum_lo_r   <= {H{1'b0}};
      sum_hi_r   <= {H{1'b0}};
      c_r        <= 1'b0;
      ovf_r      <= 1'b0;
      result_r   <= {W{1'b0}};
      overflow_r <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (beg_add_subt) begin
            // Subtraction is A + ~B + 1; the +1 rides in as the low-half carry-in
            a_r     <= data_a;
            b_r     <= op_add_subt ? ~data_b : data_b;
            cin_r   <= op_add_subt;
            busy_r  <= 1'b1;
            state_r <= ADD_LO;
          end else begin
            state_r <= IDLE;
          end
        end
        ADD_LO: begin
          sum_lo_r <= lo_sum_s[H-1:0];
          c_r      <= lo_sum_s[H];
          state_r  <= ADD_HI;
        end
        ADD_HI: begin
          sum_hi_r <= hi_sum_s;
          ovf_r    <= ovf_s;
          state_r  <= SAT;
        end
        SAT: begin
          result_r   <= sat_result_s;
          overflow_r <= ovf_r;
          ready_r    <= 1'b1;
          state_r    <= DONE;
        end
        DONE: begin
          if (ack_add_subt) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ready_add_subt = ready_r;
  assign busy           = busy_r;
  assign result         = result_r;
  assign overflow       = overflow_r;

endmodule
